seq_comparator: RTL and testbench

SEQ_COMPARATOR -- requirements
Module: seq_comparator

---
 rtl/seq_comparator.sv | 120 ++++++++++++
 tb/tb_seq_comparator.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seq_comparator.sv
`default_nettype none
// ============================================================================
// Module   : seq_comparator
// Purpose  : Multi-cycle signed/unsigned magnitude comparator. It compares one
//            CHUNK slice per cycle, MSB chunk first, and stops at the first
//            slice that differs.
// Revision : 1.0 - initial release
// ============================================================================
module seq_comparator #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             lt_o,
    output logic             eq_o,
    output logic             gt_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int              NCHUNK   = WIDTH / CHUNK;
    localparam int              IDXW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] IDX_TOP  = IDXW'(NCHUNK - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;

    logic [WIDTH-1:0] sign_mask;
    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign sign_mask = signed_i ? MSB_MASK : '0;
    assign a_slice   = a_q[idx_q*CHUNK +: CHUNK];
    assign b_slice   = b_q[idx_q*CHUNK +: CHUNK];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        case (state_q)
            ST_RUN: begin
                if (a_slice != b_slice) begin
                    lt_d    = (a_slice < b_slice);
                    gt_d    = (a_slice > b_slice);
                    state_d = ST_DONE;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q - IDX_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (start_i) begin
                    a_d     = a_i ^ sign_mask;
                    b_d     = b_i ^ sign_mask;
                    idx_d   = IDX_TOP;
                    lt_d    = 1'b0;
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
        end
    end

    assign busy_o   = (state_q == ST_RUN);
    assign done_o   = (state_q == ST_DONE);
    assign lt_o     = lt_q;
    assign eq_o     = eq_q;
    assign gt_o     = gt_q;
    assign result_o = {{(WIDTH-2){1'b0}}, gt_q, lt_q};

endmodule
`default_nettype wire

// File: tb/tb_seq_comparator.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_comparator
// Purpose  : Directed self-checking bench for seq_comparator (WIDTH=32, CHUNK=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_comparator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        lt;
    logic        eq;
    logic        gt;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;

    seq_comparator #(.WIDTH(32), .CHUNK(8)) u_dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .signed_i (sgn),
        .a_i      (a),
        .b_i      (b),
        .busy_o   (busy),
        .done_o   (done),
        .lt_o     (lt),
        .eq_o     (eq),
        .gt_o     (gt),
        .result_o (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Result code 0/1/2 -> expected {lt,eq,gt}
    function automatic logic [2:0] flags_for(input int res);
        case (res)
            0:       return 3'b010;
            1:       return 3'b100;
            default: return 3'b001;
        endcase
    endfunction

    // Called #1 after the accepting edge (or later); exp_lat counts remaining edges.
    task automatic wait_done(input string tag, input int exp_lat, input int exp_res);
        int n = 0;
        int busy_cnt = 0;
        while (!done && n < 40) begin
            if (busy) busy_cnt++;
            step();
            n++;
        end
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_busy_cycles"}, busy_cnt, exp_lat);
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_flags"}, {29'b0, lt, eq, gt}, {29'b0, flags_for(exp_res)});
        step();
        check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        check({tag, "_hold"}, result, exp_res);
    endtask

    task automatic run_cmp(input string tag, input logic [31:0] av, input logic [31:0] bv,
                           input logic s, input int exp_lat, input int exp_res);
        a = av; b = bv; sgn = s; start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_busy_start"}, {31'b0, busy}, 32'd1);
        check({tag, "_flags_clear"}, {29'b0, lt, eq, gt}, 32'd0);
        wait_done(tag, exp_lat, exp_res);
    endtask

    initial begin
        int dcnt;
        rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
        #3;
        check("reset_async_busy", {31'b0, busy}, 32'd0);
        check("reset_async_done", {31'b0, done}, 32'd0);
        check("reset_async_flags", {29'b0, lt, eq, gt}, 32'd0);
        check("reset_async_result", result, 32'd0);
        step(); step();
        rst = 1'b0;
        step();

        run_cmp("u_msb_gt",   32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1, 2);
        run_cmp("s_msb_lt",   32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1, 1);
        run_cmp("eq_full",    32'h1234_5678, 32'h1234_5678, 1'b0, 4, 0);
        run_cmp("u_lsb_lt",   32'h1234_5677, 32'h1234_5678, 1'b0, 4, 1);
        run_cmp("s_neg1_lt",  32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1, 1);
        run_cmp("u_chunk2",   32'h1234_0000, 32'h12FF_0000, 1'b0, 2, 1);
        run_cmp("s_min_eq",   32'h8000_0000, 32'h8000_0000, 1'b1, 4, 0);
        run_cmp("u_lsb_gt",   32'hABCD_EF02, 32'hABCD_EF01, 1'b0, 4, 2);

        // start with new operands during RUN must be ignored
        a = 32'h0000_0005; b = 32'h0000_0005; sgn = 1'b0; start = 1'b1;
        step();
        a = 32'h0000_0009; b = 32'h0000_0001; sgn = 1'b1;
        step();
        start = 1'b0;
        check("ign_busy", {31'b0, busy}, 32'd1);
        wait_done("ign", 3, 0);

        // start held through DONE: back-to-back with no idle cycle
        a = 32'h8000_0000; b = 32'h7FFF_FFFF; sgn = 1'b0; start = 1'b1;
        step();
        a = 32'h0000_0001; b = 32'h0000_0002;
        step();
        check("b2b_done1", {31'b0, done}, 32'd1);
        check("b2b_res1", result, 32'd2);
        step();
        start = 1'b0;
        check("b2b_busy2", {31'b0, busy}, 32'd1);
        check("b2b_done2_low", {31'b0, done}, 32'd0);
        check("b2b_flags_clear", {29'b0, lt, eq, gt}, 32'd0);
        wait_done("b2b_2", 4, 1);

        // reset asserted on the 2nd RUN cycle of an equal compare
        a = 32'h1234_5678; b = 32'h1234_5678; sgn = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("rst_mid_busy_before", {31'b0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_done", {31'b0, done}, 32'd0);
        check("rst_mid_flags", {29'b0, lt, eq, gt}, 32'd0);
        check("rst_mid_result", result, 32'd0);
        start = 1'b1;
        step();
        check("rst_ignores_start", {31'b0, busy}, 32'd0);
        start = 1'b0;
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done || busy) dcnt++;
        end
        check("rst_no_done", dcnt, 32'd0);
        check("rst_result_held0", result, 32'd0);
        run_cmp("post_rst", 32'h1234_5679, 32'h1234_5678, 1'b0, 4, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
